// File: rtl/dm_wb_cache_param.sv
// Direct-mapped write-back / write-allocate L1 data cache.
// Dirty victims are written back and lines are filled one word at a time over a req/ack L2 port.
module dm_wb_cache_param #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned INDEX_W    = 9,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              l2_req,
  output logic              l2_wr,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic [DATA_W-1:0] l2_rdata,
  input  logic              l2_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFF_W - 2;
  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned WORDS = LINES * LINE_WORDS;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  state_t             state, state_nx;
  logic [LINES-1:0]   valid, dirty;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [DATA_W-1:0]  data_mem [WORDS];
  logic [TAG_W-1:0]   miss_tag;
  logic [INDEX_W-1:0] miss_idx;
  logic [OFF_W-1:0]   beat;
  logic               refill;

  logic [TAG_W-1:0]   cpu_tag;
  logic [TAG_W-1:0]   victim_tag;
  logic [INDEX_W-1:0] cpu_idx;
  logic [OFF_W-1:0]   cpu_word;
  logic               hit, miss, last_ack, fill_done;
  logic               unused_byte_off;

  assign cpu_tag         = cpu_addr[ADDR_W-1 -: TAG_W];
  assign cpu_idx         = cpu_addr[2+OFF_W +: INDEX_W];
  assign cpu_word        = cpu_addr[2 +: OFF_W];
  assign unused_byte_off = ^cpu_addr[1:0];
  assign victim_tag      = tag_mem[miss_idx];

  assign hit       = (state == IDLE) & cpu_req & valid[cpu_idx] & (tag_mem[cpu_idx] == cpu_tag);
  assign miss      = (state == IDLE) & cpu_req & ~hit;
  assign last_ack  = l2_ack & (beat == LAST_BEAT);
  assign fill_done = (state == FILL) & last_ack;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state plus the CPU and L2 views of the current state.
  always_comb begin
    state_nx  = state;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    l2_req    = 1'b0;
    l2_wr     = 1'b0;
    l2_addr   = '0;
    l2_wdata  = '0;
    case (state)
      IDLE: begin
        cpu_ready = hit;
        if (hit && !cpu_wr) cpu_rdata = data_mem[{cpu_idx, cpu_word}];
        if (miss) state_nx = (valid[cpu_idx] & dirty[cpu_idx]) ? WB : FILL;
      end
      WB: begin
        l2_req   = 1'b1;
        l2_wr    = 1'b1;
        l2_addr  = {victim_tag, miss_idx, beat, 2'b00};
        l2_wdata = data_mem[{miss_idx, beat}];
        if (last_ack) state_nx = FILL;
      end
      FILL: begin
        l2_req  = 1'b1;
        l2_addr = {miss_tag, miss_idx, beat, 2'b00};
        if (last_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Miss bookkeeping, beat counter, line status bits and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat     <= '0;
      miss_tag <= '0;
      miss_idx <= '0;
      refill   <= 1'b0;
      valid    <= '0;
      dirty    <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      // Beat wraps to 0 on the last ack, ready for the next phase.
      if ((state != IDLE) && l2_ack) beat <= beat + OFF_W'(1);
      if (miss) begin
        miss_tag <= cpu_tag;
        miss_idx <= cpu_idx;
        refill   <= 1'b1;
        if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CNT_W'(1);
      end
      if (cpu_ready) begin
        refill <= 1'b0;
        if (!refill && (hit_cnt != CNT_MAX)) hit_cnt <= hit_cnt + CNT_W'(1);
        if (cpu_wr) dirty[cpu_idx] <= 1'b1;
      end
      if (fill_done) begin
        valid[miss_idx] <= 1'b1;
        dirty[miss_idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; valid/dirty alone qualify their contents.
  always_ff @(posedge clk) begin
    if (cpu_ready && cpu_wr)        data_mem[{cpu_idx, cpu_word}] <= cpu_wdata;
    if ((state == FILL) && l2_ack)  data_mem[{miss_idx, beat}]    <= l2_rdata;
    if (fill_done)                  tag_mem[miss_idx]             <= miss_tag;
  end

endmodule

// File: tb/tb_dm_wb_cache_param.sv
// Self-checking bench for dm_wb_cache_param: directed vector table, reset/saturation sequences,
// and randomized accesses checked against a line-level cache model over a flat golden memory.
module tb_dm_wb_cache_param;

  localparam int unsigned CW     = 4;
  localparam int          BUDGET = 400;

  logic        clk, rst_n;
  logic        cpu_req, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        l2_req, l2_wr;
  logic [31:0] l2_addr, l2_wdata, l2_rdata;
  logic        l2_ack;
  logic [CW-1:0] hit_cnt, miss_cnt;

  dm_wb_cache_param #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .l2_req(l2_req), .l2_wr(l2_wr), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_ack(l2_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } xact_t;
  typedef struct {
    logic wr; logic [31:0] addr; logic [31:0] wdata;
    bit exp_hit; bit exp_wb; logic [31:0] exp_rdata;
    logic [3:0] exp_hits; logic [3:0] exp_misses;
    bit chk_l2; logic [31:0] l2a; logic [31:0] l2v;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // L2 backing store and the architectural (latest-written) memory image.
  logic [31:0] l2mem  [logic [31:0]];
  logic [31:0] golden [logic [31:0]];

  // Which line each index currently holds and whether it has unwritten stores.
  bit          m_valid [512];
  bit          m_dirty [512];
  logic [17:0] m_tag   [512];
  int          m_hits, m_misses;

  bit          last_hit, last_wb;
  logic [31:0] last_rd;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[17:2]};
  endfunction

  function automatic logic [31:0] l2_rd(input logic [31:0] a);
    if (l2mem.exists(a)) return l2mem[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] g_rd(input logic [31:0] a);
    if (golden.exists(a)) return golden[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] sat(input int n);
    return (n > 15) ? 32'd15 : 32'(n);
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_valid[k]) begin
      m_valid[k] = 1'b0;
      m_dirty[k] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
    golden   = l2mem;
  endtask

  task automatic do_reset();
    cpu_req = 1'b0;
    l2_ack  = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check1 ("rst_cpu_ready", cpu_ready, 1'b0);
    check32("rst_cpu_rdata", cpu_rdata, 32'h0);
    check1 ("rst_l2_req",    l2_req,    1'b0);
    check1 ("rst_l2_wr",     l2_wr,     1'b0);
    check32("rst_l2_addr",   l2_addr,   32'h0);
    check32("rst_l2_wdata",  l2_wdata,  32'h0);
    check32("rst_hit_cnt",   32'(hit_cnt),  32'h0);
    check32("rst_miss_cnt",  32'(miss_cnt), 32'h0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // One CPU access; the L2 side is serviced with random ack latency and spurious idle acks.
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    xact_t       exp_q[$];
    xact_t       got_q[$];
    xact_t       x, prev;
    logic [31:0] wa, exp_rd, rd;
    logic [8:0]  i;
    logic [17:0] t;
    bit          exp_hit, done, pend;
    int          cyc;

    wa = {a[31:2], 2'b00};
    i  = a[13:5];
    t  = a[31:14];
    exp_hit = m_valid[i] && (m_tag[i] == t);
    if (!exp_hit) begin
      if (m_valid[i] && m_dirty[i]) begin
        for (int b = 0; b < 8; b++) begin
          x.wr = 1'b1; x.addr = {m_tag[i], i, 3'(b), 2'b00}; x.data = g_rd(x.addr);
          exp_q.push_back(x);
        end
      end
      for (int b = 0; b < 8; b++) begin
        x.wr = 1'b0; x.addr = {t, i, 3'(b), 2'b00}; x.data = 32'h0;
        exp_q.push_back(x);
      end
      m_valid[i] = 1'b1; m_tag[i] = t; m_dirty[i] = 1'b0;
      m_misses++;
    end else begin
      m_hits++;
    end
    exp_rd = wr ? 32'h0 : g_rd(wa);
    if (wr) begin
      golden[wa] = wd;
      m_dirty[i] = 1'b1;
    end

    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = wd;
    done = 1'b0; pend = 1'b0; cyc = 0; rd = 32'h0;
    prev.wr = 1'b0; prev.addr = 32'h0; prev.data = 32'h0;
    while (!done && cyc < BUDGET) begin
      #1;
      if (pend) begin
        check1 ("hold_req",   l2_req,   1'b1);
        check1 ("hold_wr",    l2_wr,    prev.wr);
        check32("hold_addr",  l2_addr,  prev.addr);
        check32("hold_wdata", l2_wdata, prev.data);
      end
      if (cpu_ready) begin
        rd = cpu_rdata;
        done = 1'b1;
        l2_ack = 1'b0;
        pend = 1'b0;
        check1("ready_l2_req", l2_req, 1'b0);
      end else if (l2_req) begin
        l2_ack = ($urandom_range(0, 2) != 0);
        x.wr = l2_wr; x.addr = l2_addr; x.data = l2_wdata;
        if (l2_ack) begin
          got_q.push_back(x);
          if (l2_wr) l2mem[l2_addr] = l2_wdata;
          else       l2_rdata = l2_rd(l2_addr);
        end else begin
          l2_rdata = $urandom;
        end
        pend = !l2_ack;
        prev = x;
      end else begin
        l2_ack   = ($urandom_range(0, 3) == 0);
        l2_rdata = $urandom;
        pend     = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    cpu_req = 1'b0;
    l2_ack  = 1'b0;

    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL timeout: access 0x%08h got no cpu_ready in %0d cycles, want ready", a, cyc);
    end
    check32("xact_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      check1 ("xact_wr",   got_q[k].wr,   exp_q[k].wr);
      check32("xact_addr", got_q[k].addr, exp_q[k].addr);
      if (exp_q[k].wr) check32("xact_wdata", got_q[k].data, exp_q[k].data);
    end
    check32("rdata", rd, exp_rd);
    if (exp_hit) check32("hit_latency", 32'(cyc), 32'd1);
    check32("hit_cnt",  32'(hit_cnt),  sat(m_hits));
    check32("miss_cnt", 32'(miss_cnt), sat(m_misses));

    last_hit = done && (cyc == 1) && (got_q.size() == 0);
    last_wb  = 1'b0;
    foreach (got_q[k]) if (got_q[k].wr) last_wb = 1'b1;
    last_rd  = rd;
  endtask

  initial begin
    vec_t tv [8];
    bit   found;

    rst_n = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    l2_ack = 1'b0; l2_rdata = 32'h0;
    for (int b = 0; b < 8; b++) begin
      l2mem[32'h0000_4020 + 32'(4*b)] = 32'hA0 + 32'(b);
      l2mem[32'h0000_8020 + 32'(4*b)] = 32'hB0 + 32'(b);
    end

    //           wr    addr          wdata         hit   wb    rdata               hits  misses chk  l2a           l2v
    tv[0] = '{1'b0, 32'h0000_4020, 32'h0,        1'b0, 1'b0, 32'hA0,             4'd0, 4'd1, 1'b0, 32'h0,        32'h0};
    tv[1] = '{1'b0, 32'h0000_402C, 32'h0,        1'b1, 1'b0, 32'hA3,             4'd1, 4'd1, 1'b0, 32'h0,        32'h0};
    tv[2] = '{1'b1, 32'h0000_4024, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,              4'd2, 4'd1, 1'b0, 32'h0,        32'h0};
    tv[3] = '{1'b0, 32'h0000_8024, 32'h0,        1'b0, 1'b1, 32'hB1,             4'd2, 4'd2, 1'b1, 32'h0000_4024, 32'hDEADBEEF};
    tv[4] = '{1'b1, 32'h0000_C000, 32'h12345678, 1'b0, 1'b0, 32'h0,              4'd2, 4'd3, 1'b0, 32'h0,        32'h0};
    tv[5] = '{1'b0, 32'h0001_0000, 32'h0,        1'b0, 1'b1, init_val(32'h10000), 4'd2, 4'd4, 1'b1, 32'h0000_C000, 32'h12345678};
    tv[6] = '{1'b0, 32'h0000_C000, 32'h0,        1'b0, 1'b0, 32'h12345678,       4'd2, 4'd5, 1'b0, 32'h0,        32'h0};
    tv[7] = '{1'b0, 32'h0000_C004, 32'h0,        1'b1, 1'b0, init_val(32'hC004), 4'd3, 4'd5, 1'b0, 32'h0,        32'h0};

    @(negedge clk);
    do_reset();

    for (int k = 0; k < 8; k++) begin
      access(tv[k].wr, tv[k].addr, tv[k].wdata);
      check1 ($sformatf("t%0d_hit", k),   last_hit, tv[k].exp_hit);
      check1 ($sformatf("t%0d_wb", k),    last_wb,  tv[k].exp_wb);
      check32($sformatf("t%0d_rdata", k), last_rd,  tv[k].exp_rdata);
      check32($sformatf("t%0d_hits", k),  32'(hit_cnt),  32'(tv[k].exp_hits));
      check32($sformatf("t%0d_miss", k),  32'(miss_cnt), 32'(tv[k].exp_misses));
      if (tv[k].chk_l2) check32($sformatf("t%0d_l2mem", k), l2_rd(tv[k].l2a), tv[k].l2v);
    end

    // Reset in the middle of a fill: l2_req must drop at once and valid lines are forgotten.
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0002_0020;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      #1;
      if (l2_req && !l2_wr && (l2_addr == 32'h0002_002C)) begin
        found = 1'b1;
      end else begin
        l2_ack = l2_req;
        l2_rdata = 32'h77;
        @(negedge clk);
      end
    end
    check1("fill_beat3_seen", found, 1'b1);
    l2_ack = 1'b0;
    rst_n  = 1'b0;
    #1;
    check1 ("midfill_l2_req",    l2_req,    1'b0);
    check1 ("midfill_cpu_ready", cpu_ready, 1'b0);
    check32("midfill_hit_cnt",   32'(hit_cnt),  32'h0);
    check32("midfill_miss_cnt",  32'(miss_cnt), 32'h0);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    access(1'b0, 32'h0002_0020, 32'h0);
    check1 ("postrst_refill_miss", last_hit, 1'b0);
    access(1'b0, 32'h0000_C004, 32'h0);
    check1 ("postrst_old_line_miss", last_hit, 1'b0);
    check32("postrst_miss_cnt", 32'(miss_cnt), 32'd2);

    // Counter saturation with 4-bit counters.
    do_reset();
    for (int n = 0; n < 17; n++) access(1'b0, (32'(16 + n) << 14) | 32'h40, 32'h0);
    check32("miss_saturated", 32'(miss_cnt), 32'hF);
    for (int n = 0; n < 20; n++) access(1'b0, (32'd32 << 14) | 32'h44, 32'h0);
    check32("hit_saturated", 32'(hit_cnt), 32'hF);

    // Random mix over a small set of conflicting lines.
    do_reset();
    for (int n = 0; n < 200; n++) begin
      logic [31:0] ra;
      ra = (32'($urandom_range(1, 4)) << 14) | (32'($urandom_range(0, 3)) << 5)
         | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), ra, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
